// File: rtl/ntt_dma_pkg.sv
// Shared types and helpers for the NTT engine DMA arbiter.
package ntt_dma_pkg;
    localparam int ADDR_W_DEF = 48;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/ntt_dma_id_fifo.sv
// In-order FIFO of requester IDs for reads awaiting their memory response.
module ntt_dma_id_fifo
    import ntt_dma_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
endmodule

// File: rtl/ntt_dma_arbiter.sv
// Round-robin arbiter sharing one host DMA port among NTT cores, with
// in-order read-response routing back to the issuing core.
module ntt_dma_arbiter
    import ntt_dma_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int ID_W            = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            core_req,
    input  logic [NUM_CORES-1:0]            core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]     core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]     core_wdata,
    output logic [NUM_CORES-1:0]            core_gnt,
    output logic [NUM_CORES-1:0]            core_valid,
    output logic [DATA_W-1:0]               core_rdata,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic                            mem_ready,
    input  logic                            mem_rvalid,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                            err_spurious
);
    state_t              state_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     win_id_reg;
    logic [ID_W-1:0]     win_idx;
    logic                win_found;
    logic [NUM_CORES-1:0] eligible;
    logic [ADDR_W-1:0]   addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]   wdata_arr [NUM_CORES];

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ID_W-1:0]     fifo_dout;

    // Reads need a free FIFO slot (registered full flag); writes never wait on it.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign addr_arr[gi]  = core_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = core_wdata[gi*DATA_W +: DATA_W];
            assign eligible[gi]  = core_req[gi] && (core_we[gi] || !fifo_full);
        end
    endgenerate

    always_comb begin
        int              c;
        logic [ID_W-1:0] c_id;
        win_found = 1'b0;
        win_idx   = '0;
        c         = 0;
        c_id      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            c    = (int'(rr_ptr_reg) + k) % NUM_CORES;
            c_id = ID_W'(c);
            if (!win_found && eligible[c_id]) begin
                win_found = 1'b1;
                win_idx   = c_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_ARB;
            rr_ptr_reg <= '0;
            win_id_reg <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_gnt   <= '0;
        end else begin
            core_gnt <= '0;
            case (state_reg)
                S_ARB: begin
                    if (win_found) begin
                        mem_req    <= 1'b1;
                        mem_we     <= core_we[win_idx];
                        mem_addr   <= addr_arr[win_idx];
                        mem_wdata  <= wdata_arr[win_idx];
                        win_id_reg <= win_idx;
                        state_reg  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_req              <= 1'b0;
                        core_gnt[win_id_reg] <= 1'b1;
                        rr_ptr_reg <= (win_id_reg == ID_W'(NUM_CORES - 1)) ? '0 : win_id_reg + 1'b1;
                        state_reg  <= S_GAP;
                    end
                end
                // The granted core still holds req here; skipping arbitration avoids a re-grant.
                S_GAP:   state_reg <= S_ARB;
                default: state_reg <= S_ARB;
            endcase
        end
    end

    assign fifo_push = (state_reg == S_ISSUE) && mem_ready && !mem_we;
    assign fifo_pop  = mem_rvalid && !fifo_empty;

    ntt_dma_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (win_id_reg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid   <= '0;
            core_rdata   <= '0;
            err_spurious <= 1'b0;
        end else begin
            core_valid <= '0;
            if (mem_rvalid) begin
                if (!fifo_empty) begin
                    core_valid[fifo_dout] <= 1'b1;
                    core_rdata            <= mem_rdata;
                end else begin
                    err_spurious <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/ntt_dma_arbiter.md
Name: ntt_dma_arbiter

Overview:
- Shares one host-memory DMA port between NUM_CORES NTT engine cores.
- Uses round-robin arbitration over each core's req/gnt/valid DMA interface.
- Issues one transaction at a time downstream. Tracks outstanding reads in an in-order ID FIFO and routes each read response back to the core that issued it.
- Sits between the engine array and the memory controller.

Parameters:
- NUM_CORES, 4, number of requesting engines (2..8)
- ID_W, 2, requester ID width, equal to clog2(NUM_CORES)
- MAX_OUTSTANDING, 4, depth of the read-ID FIFO (power of 2)
- ADDR_W, 48, DMA byte address width
- DATA_W, 64, data word width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_req  in  NUM_CORES  per-core request, level, held until gnt seen
- core_we  in  NUM_CORES  per-core write enable (1 = write)
- core_addr  in  NUM_CORES*ADDR_W  flattened; core i at bits [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  flattened write data, same packing
- core_gnt  out  NUM_CORES  one-cycle grant pulse, one-hot or zero
- core_valid  out  NUM_CORES  one-cycle read-data-valid pulse, one-hot or zero
- core_rdata  out  DATA_W  read data, broadcast to all cores, qualified by core_valid
- mem_req  out  1  downstream request, held until mem_ready
- mem_we  out  1  downstream write enable
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_ready  in  1  downstream accepts in any cycle where mem_req && mem_ready
- mem_rvalid  in  1  read response valid; responses return in issue order; writes produce none
- mem_rdata  in  DATA_W  read response data
- outstanding  out  clog2(MAX_OUTSTANDING)+1  reads issued but not yet returned
- err_spurious  out  1  sticky; set by mem_rvalid while the ID FIFO is empty

Behaviour:
- Reset values:
  - All outputs 0.
  - State S_ARB, rr_ptr = 0, FIFO empty, err_spurious = 0.
- Reset mid-operation: aborts the transaction in flight. Responses arriving after reset are spurious: they are dropped and set err_spurious.

State machine:
- S_ARB:
  - Eligible core: core_req[i]=1, and if core_we[i]=0 then the FIFO must not be full.
  - Winner: first eligible core scanning from rr_ptr upward, modulo NUM_CORES.
  - On a winner: register mem_req=1, mem_we, mem_addr, mem_wdata from the winner; latch win_id; go to S_ISSUE.
  - No eligible core: stay in S_ARB.
- S_ISSUE:
  - Hold mem_* stable until mem_req && mem_ready.
  - On accept: mem_req<=0; core_gnt[win_id]<=1 for the next cycle only; rr_ptr<=win_id+1 mod NUM_CORES; if a read, push win_id into the FIFO; go to S_GAP.
- S_GAP:
  - Lasts one cycle, the cycle in which core_gnt is high. The core deasserts req at the following edge.
  - Go to S_ARB. No arbitration happens in S_GAP, so a stale req is never re-granted.
- Throughput: at most one transaction per 3 cycles when mem_ready is held high.

Response routing:
- When mem_rvalid and the FIFO is non-empty: pop the head ID. Next cycle, core_valid[id]=1 and core_rdata=mem_rdata. Latency is 1 cycle.
- When mem_rvalid and the FIFO is empty: no core_valid, err_spurious<=1.
- A push and a pop in the same cycle are both legal, including when the FIFO is full: count unchanged, order preserved.
- Eligibility uses the registered full flag, so a same-cycle pop does not unblock a read request.
- outstanding = FIFO count.

Other rules:
- A write never blocks on FIFO full.
- core_gnt and core_valid may be high in the same cycle for the same core or for different cores.

Decomposition:
- Package ntt_dma_pkg holds:
  - ADDR_W and DATA_W defaults
  - state encoding: S_ARB=0, S_ISSUE=1, S_GAP=2
  - clog2 helper function
- Sub-module ntt_dma_id_fifo: synchronous FIFO with width ID_W and depth MAX_OUTSTANDING; ports push, pop, din, dout, full, empty, count; async reset.

Test Plan:
- Single core 0 read: addr 0x1000, mem_ready=1, response 3 cycles later with 0xDEADBEEF.
  -> core_gnt[0] pulses once; mem_addr=0x1000; core_valid[0] pulses one cycle after mem_rvalid with rdata 0xDEADBEEF; outstanding goes 0→1→0.
- Cores 0–3 request reads continuously.
  -> Grants in order 0,1,2,3,0; each core_gnt one cycle wide; no core granted twice consecutively while the others are requesting.
- Reads from 1,3,2 issued, responses 0xA, 0xB, 0xC returned in order.
  -> core_valid pulses on 1, then 3, then 2, with matching data.
- FIFO full: 4 reads outstanding and a 5th read pending.
  -> No grant until the first response.
  -> A write request from another core is still granted while the FIFO is full.
- mem_ready held low for 5 cycles.
  -> mem_addr and mem_wdata stable; no core_gnt until the accept cycle.
- Reset with 2 reads outstanding, then 1 late mem_rvalid.
  -> All outputs 0 after reset; late response dropped; err_spurious=1.
